// File: rtl/approx_error_monitor.sv
// Streaming error-statistics monitor for a 32-bit approximate adder.
// Define APPROX_ERR_HAMMING_EN to add the report_sum_hd Hamming-distance accumulator.
module approx_error_monitor #(
    parameter int unsigned WINDOW = 256,
    parameter int unsigned SUM_W  = 48
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [31:0]       A,
    input  logic [31:0]       B,
    input  logic [31:0]       ApproxSum,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              flush,
    output logic              report_valid,
    input  logic              report_ready,
    output logic [16:0]       report_count,
    output logic [16:0]       report_err_count,
    output logic [32:0]       report_max_ed,
    output logic [SUM_W-1:0]  report_sum_ed
`ifdef APPROX_ERR_HAMMING_EN
    ,
    output logic [31:0]       report_sum_hd
`endif
);

    typedef enum logic [1:0] {StAccum, StDrain, StReport} state_e;

    state_e            state_q, state_d;
    logic              accept, last_accept, clear;
    logic [32:0]       exact_sum, approx_ext, ed;
    logic [SUM_W:0]    sum_ext;
    logic [16:0]       win_cnt_q;
    logic              s1_valid_q;
    logic [32:0]       s1_ed_q;
    logic [16:0]       count_q, err_count_q;
    logic [32:0]       max_ed_q;
    logic [SUM_W-1:0]  sum_ed_q;

    assign in_ready    = (state_q == StAccum);
    assign accept      = in_valid && in_ready;
    // win_cnt_q counts accepts directly, so the window closes without waiting on the pipeline
    assign last_accept = accept && (win_cnt_q == 17'(WINDOW - 1));
    assign clear       = (state_q == StReport) && report_ready;

    assign exact_sum  = {1'b0, A} + {1'b0, B};
    assign approx_ext = {1'b0, ApproxSum};
    assign ed         = (exact_sum >= approx_ext) ? (exact_sum - approx_ext)
                                                  : (approx_ext - exact_sum);
    assign sum_ext    = {1'b0, sum_ed_q} + (SUM_W + 1)'(s1_ed_q);

`ifdef APPROX_ERR_HAMMING_EN
    logic [5:0]  s1_hd_q;
    logic [31:0] sum_hd_q;
    logic [32:0] hd_ext;
    assign hd_ext        = {1'b0, sum_hd_q} + 33'(s1_hd_q);
    assign report_sum_hd = sum_hd_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            s1_hd_q  <= '0;
            sum_hd_q <= '0;
        end else begin
            if (accept) s1_hd_q <= 6'($countones(exact_sum[31:0] ^ ApproxSum));
            if (clear) sum_hd_q <= '0;
            else if (s1_valid_q) sum_hd_q <= hd_ext[32] ? '1 : hd_ext[31:0];
        end
    end
`endif

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StAccum:  if (flush || last_accept) state_d = StDrain;
            StDrain:  if (!s1_valid_q) state_d = StReport;
            StReport: if (report_ready) state_d = StAccum;
            default:  state_d = StAccum;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= StAccum;
            win_cnt_q   <= '0;
            s1_valid_q  <= 1'b0;
            s1_ed_q     <= '0;
            count_q     <= '0;
            err_count_q <= '0;
            max_ed_q    <= '0;
            sum_ed_q    <= '0;
        end else begin
            state_q    <= state_d;
            s1_valid_q <= accept;
            if (accept) s1_ed_q <= ed;
            if (clear) begin
                win_cnt_q   <= '0;
                count_q     <= '0;
                err_count_q <= '0;
                max_ed_q    <= '0;
                sum_ed_q    <= '0;
            end else begin
                if (accept) win_cnt_q <= win_cnt_q + 17'd1;
                if (s1_valid_q) begin
                    count_q     <= count_q + 17'd1;
                    err_count_q <= err_count_q + 17'(s1_ed_q != '0);
                    if (s1_ed_q > max_ed_q) max_ed_q <= s1_ed_q;
                    sum_ed_q    <= sum_ext[SUM_W] ? '1 : sum_ext[SUM_W-1:0];
                end
            end
        end
    end

    assign report_valid     = (state_q == StReport);
    assign report_count     = count_q;
    assign report_err_count = err_count_q;
    assign report_max_ed    = max_ed_q;
    assign report_sum_ed    = sum_ed_q;

endmodule

// File: tb/tb_approx_error_monitor.sv
// Directed self-checking bench for approx_error_monitor (WINDOW=4, SUM_W=34).
// Honours APPROX_ERR_HAMMING_EN to also check report_sum_hd.
module tb_approx_error_monitor;

    localparam int unsigned SW = 34;

    logic          clock = 1'b0;
    logic          reset, in_valid, in_ready, flush, report_valid, report_ready;
    logic [31:0]   A, B, ApproxSum;
    logic [16:0]   report_count, report_err_count;
    logic [32:0]   report_max_ed;
    logic [SW-1:0] report_sum_ed;
`ifdef APPROX_ERR_HAMMING_EN
    logic [31:0]   report_sum_hd;
`endif

    int tests = 0;
    int fails = 0;

    approx_error_monitor #(.WINDOW(4), .SUM_W(SW)) dut (
        .clock            (clock),
        .reset            (reset),
        .A                (A),
        .B                (B),
        .ApproxSum        (ApproxSum),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .flush            (flush),
        .report_valid     (report_valid),
        .report_ready     (report_ready),
        .report_count     (report_count),
        .report_err_count (report_err_count),
        .report_max_ed    (report_max_ed),
        .report_sum_ed    (report_sum_ed)
`ifdef APPROX_ERR_HAMMING_EN
        ,
        .report_sum_hd    (report_sum_hd)
`endif
    );

    always #5 clock = ~clock;

    // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic [31:0] s);
        A = a; B = b; ApproxSum = s; in_valid = 1'b1;
    endtask

    task automatic handshake();
        report_ready = 1'b1;
        step();
        report_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b1; flush = 1'b1; report_ready = 1'b1;
        A = '0; B = '0; ApproxSum = 32'h1;
        step(); step();
        reset = 1'b0; in_valid = 1'b0; flush = 1'b0; report_ready = 1'b0;
        tests++;
        if ({in_ready, report_valid} !== 2'b10) begin
            fails++; $display("FAIL reset_hs: in_ready,report_valid=%b want 10", {in_ready, report_valid});
        end
        tests++;
        if ({report_count, report_err_count, report_max_ed, report_sum_ed} !== '0) begin
            fails++; $display("FAIL reset_stats: got %h want 0",
                              {report_count, report_err_count, report_max_ed, report_sum_ed});
        end
    endtask

    task automatic test_window();
        for (int i = 0; i < 4; i++) begin
            drive(32'd5, 32'd3, (i == 3) ? 32'd7 : 32'd8);
            step();
        end
        in_valid = 1'b0;
        tests++;
        if ({report_valid, in_ready} !== 2'b00) begin
            fails++; $display("FAIL win_drain0: report_valid,in_ready=%b want 00", {report_valid, in_ready});
        end
        step();
        tests++;
        if (report_valid !== 1'b0) begin
            fails++; $display("FAIL win_drain1: report_valid=%b want 0", report_valid);
        end
        step();
        tests++;
        if (report_valid !== 1'b1) begin
            fails++; $display("FAIL win_latency: report_valid=%b want 1", report_valid);
        end
        tests++;
        if ({report_count, report_err_count, report_max_ed, report_sum_ed} !==
            {17'd4, 17'd1, 33'd1, 34'd1}) begin
            fails++; $display("FAIL win_stats: got %h want %h",
                              {report_count, report_err_count, report_max_ed, report_sum_ed},
                              {17'd4, 17'd1, 33'd1, 34'd1});
        end
`ifdef APPROX_ERR_HAMMING_EN
        tests++;
        if (report_sum_hd !== 32'd4) begin
            fails++; $display("FAIL win_hd: got %0d want 4", report_sum_hd);
        end
`endif
        handshake();
        tests++;
        if ({in_ready, report_valid, report_count} !== {2'b10, 17'd0}) begin
            fails++; $display("FAIL win_clear: in_ready,report_valid,count=%h want %h",
                              {in_ready, report_valid, report_count}, {2'b10, 17'd0});
        end
    endtask

    task automatic test_carry_flush();
        drive(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        step();
        in_valid = 1'b0; flush = 1'b1;
        step();
        flush = 1'b0;
        step();
        tests++;
        if ({report_valid, report_count, report_err_count, report_max_ed, report_sum_ed} !==
            {1'b1, 17'd1, 17'd1, 33'h1_0000_0000, 34'h1_0000_0000}) begin
            fails++; $display("FAIL carry_stats: got %h want %h",
                              {report_valid, report_count, report_err_count, report_max_ed, report_sum_ed},
                              {1'b1, 17'd1, 17'd1, 33'h1_0000_0000, 34'h1_0000_0000});
        end
`ifdef APPROX_ERR_HAMMING_EN
        tests++;
        if (report_sum_hd !== 32'd0) begin
            fails++; $display("FAIL carry_hd: got %0d want 0", report_sum_hd);
        end
`endif
        handshake();
    endtask

    task automatic test_empty_flush();
        flush = 1'b1;
        step();
        flush = 1'b0;
        tests++;
        if ({in_ready, report_valid} !== 2'b00) begin
            fails++; $display("FAIL empty_drain: in_ready,report_valid=%b want 00", {in_ready, report_valid});
        end
        step();
        tests++;
        if ({report_valid, in_ready, report_count, report_err_count, report_max_ed, report_sum_ed} !==
            {2'b10, 101'd0}) begin
            fails++; $display("FAIL empty_stats: got %h want %h",
                              {report_valid, in_ready, report_count, report_err_count, report_max_ed,
                               report_sum_ed}, {2'b10, 101'd0});
        end
        step(); step();
        tests++;
        if ({report_valid, in_ready} !== 2'b10) begin
            fails++; $display("FAIL empty_hold: report_valid,in_ready=%b want 10", {report_valid, in_ready});
        end
        handshake();
        tests++;
        if (in_ready !== 1'b1) begin
            fails++; $display("FAIL empty_ready: in_ready=%b want 1", in_ready);
        end
    endtask

    task automatic test_back_to_back();
        int bad = 0;
        for (int i = 0; i < 4; i++) begin
            drive(32'd5, 32'd3, 32'd8);
            step();
        end
        drive(32'd1, 32'd1, 32'd0);
        step(); step();
        for (int i = 0; i < 10; i++) begin
            if ({in_ready, report_valid, report_count, report_err_count, report_max_ed,
                 report_sum_ed} !== {2'b01, 17'd4, 84'd0}) bad++;
            step();
        end
        tests++;
        if (bad != 0) begin
            fails++; $display("FAIL stall_stable: %0d unstable cycles want 0", bad);
        end
        handshake();
        tests++;
        if ({in_ready, report_count} !== {1'b1, 17'd0}) begin
            fails++; $display("FAIL stall_clear: in_ready,count=%h want %h",
                              {in_ready, report_count}, {1'b1, 17'd0});
        end
        flush = 1'b1;
        step();
        in_valid = 1'b0; flush = 1'b0;
        step(); step();
        tests++;
        if ({report_valid, report_count, report_err_count, report_max_ed, report_sum_ed} !==
            {1'b1, 17'd1, 17'd1, 33'd2, 34'd2}) begin
            fails++; $display("FAIL stall_next: got %h want %h",
                              {report_valid, report_count, report_err_count, report_max_ed, report_sum_ed},
                              {1'b1, 17'd1, 17'd1, 33'd2, 34'd2});
        end
        handshake();
    endtask

    task automatic test_reset_drain();
        drive(32'd5, 32'd3, 32'd0);
        flush = 1'b1;
        step();
        in_valid = 1'b0; flush = 1'b0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        tests++;
        if ({in_ready, report_valid, report_count} !== {2'b10, 17'd0}) begin
            fails++; $display("FAIL rst_drain: in_ready,report_valid,count=%h want %h",
                              {in_ready, report_valid, report_count}, {2'b10, 17'd0});
        end
        drive(32'd5, 32'd3, 32'd8);
        flush = 1'b1;
        step();
        in_valid = 1'b0; flush = 1'b0;
        step(); step();
        tests++;
        if ({report_valid, report_count, report_err_count, report_max_ed, report_sum_ed} !==
            {1'b1, 17'd1, 84'd0}) begin
            fails++; $display("FAIL rst_next: got %h want %h",
                              {report_valid, report_count, report_err_count, report_max_ed, report_sum_ed},
                              {1'b1, 17'd1, 84'd0});
        end
        handshake();
    endtask

    task automatic test_saturation();
        // ED per sample: (2^33 - 2) - 0
        drive(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0);
        step();
        flush = 1'b1;
        step();
        in_valid = 1'b0; flush = 1'b0;
        step(); step();
        tests++;
        if ({report_valid, report_count, report_err_count, report_max_ed, report_sum_ed} !==
            {1'b1, 17'd2, 17'd2, 33'h1_FFFF_FFFE, 34'h3_FFFF_FFFC}) begin
            fails++; $display("FAIL sat_two: got %h want %h",
                              {report_valid, report_count, report_err_count, report_max_ed, report_sum_ed},
                              {1'b1, 17'd2, 17'd2, 33'h1_FFFF_FFFE, 34'h3_FFFF_FFFC});
        end
`ifdef APPROX_ERR_HAMMING_EN
        tests++;
        if (report_sum_hd !== 32'd62) begin
            fails++; $display("FAIL sat_hd2: got %0d want 62", report_sum_hd);
        end
`endif
        handshake();
        for (int i = 0; i < 4; i++) begin
            drive(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0);
            step();
        end
        in_valid = 1'b0;
        step(); step();
        tests++;
        if ({report_valid, report_count, report_err_count, report_max_ed, report_sum_ed} !==
            {1'b1, 17'd4, 17'd4, 33'h1_FFFF_FFFE, 34'h3_FFFF_FFFF}) begin
            fails++; $display("FAIL sat_four: got %h want %h",
                              {report_valid, report_count, report_err_count, report_max_ed, report_sum_ed},
                              {1'b1, 17'd4, 17'd4, 33'h1_FFFF_FFFE, 34'h3_FFFF_FFFF});
        end
`ifdef APPROX_ERR_HAMMING_EN
        tests++;
        if (report_sum_hd !== 32'd124) begin
            fails++; $display("FAIL sat_hd4: got %0d want 124", report_sum_hd);
        end
`endif
        handshake();
    endtask

    initial begin
        test_reset();
        test_window();
        test_carry_flush();
        test_empty_flush();
        test_back_to_back();
        test_reset_drain();
        test_saturation();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
